// File: rtl/pipe_decode_stage.sv
// Decode pipeline stage: one valid/ready register, bus-select decode, load-use scoreboard.
// Optional ILLEGAL_TRAP_EN makes the illegal flag sticky and stalls the stage until flush.
module pipe_decode_stage #(
  parameter int unsigned INSTR_W   = 8,
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned ALU_SEL   = 8,
  parameter int unsigned IMM_SEL   = 5,
  parameter int unsigned HAZ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [SEL_W-1:0]   MainAssert,
  output logic [SEL_W-1:0]   MainLoad,
  output logic               illegal
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [7:0]         op;
  logic               is_mov;
  logic               dec_illegal;
  logic [SEL_W-1:0]   dec_assert;
  logic [SEL_W-1:0]   dec_load;
  logic [SEL_W-1:0]   retire_load;
  logic               hazard;
  logic               blocked;
  logic               accept;
  logic               retire;

  assign op     = instr_q[7:0];
  assign is_mov = (op[7:6] == 2'b01);

  // Priority decode of the held opcode into bus source/destination selects
  always_comb begin
    dec_assert  = '0;
    dec_load    = '0;
    dec_illegal = 1'b0;
    if (is_mov) begin
      dec_load   = SEL_W'(op[5:3]);
      dec_assert = SEL_W'(op[2:0]);
    end else if (op[7:4] inside {4'd1, 4'd2, 4'd9, 4'd10, 4'd11}) begin
      dec_assert = SEL_W'(ALU_SEL);
      dec_load   = SEL_W'({1'b0, op[3:2]} + 3'd1);
    end else if (op[7:3] == 5'b00001) begin
      dec_load   = SEL_W'(op[2:0]);
      dec_assert = SEL_W'(IMM_SEL);
    end else if (op[7:2] inside {6'd1, 6'd12, 6'd32, 6'd33, 6'd34}) begin
      dec_assert = SEL_W'(ALU_SEL);
      dec_load   = SEL_W'({1'b0, op[1:0]} + 3'd1);
    end else if (op != 8'h00) begin
      dec_illegal = 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (flush) begin
      illegal_q <= 1'b0;
    end else if (valid_q && dec_illegal) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q | (valid_q & dec_illegal);
  assign blocked = illegal;
`else
  assign illegal = valid_q & dec_illegal;
  assign blocked = 1'b0;
`endif

  assign out_valid   = valid_q && !hazard && !blocked;
  assign in_ready    = rst_n && !flush && !blocked && (!valid_q || (out_ready && !hazard));
  assign accept      = in_valid && in_ready;
  assign retire      = out_valid && out_ready;
  assign MainAssert  = out_valid ? dec_assert : '0;
  assign MainLoad    = out_valid ? dec_load : '0;
  assign out_instr   = instr_q;
  assign retire_load = retire ? MainLoad : '0;

  // Pipeline register; flush wins over accept and retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      instr_q <= in_instr;
    end else if (retire) begin
      valid_q <= 1'b0;
    end
  end

  generate
    if (HAZ_DEPTH > 0) begin : g_sb
      logic [SEL_W-1:0] sb_q [HAZ_DEPTH];
      logic             hit;

      // Shift register of recently retired destinations, newest in entry 0
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < int'(HAZ_DEPTH); k++) sb_q[k] <= '0;
        end else if (flush) begin
          for (int k = 0; k < int'(HAZ_DEPTH); k++) sb_q[k] <= '0;
        end else begin
          sb_q[0] <= retire_load;
          for (int k = 1; k < int'(HAZ_DEPTH); k++) sb_q[k] <= sb_q[k-1];
        end
      end

      always_comb begin
        hit = 1'b0;
        for (int k = 0; k < int'(HAZ_DEPTH); k++) begin
          if (sb_q[k] == SEL_W'(op[2:0])) hit = 1'b1;
        end
      end

      // A mov reading a register still in flight must wait for it to age out
      assign hazard = valid_q && is_mov && (op[2:0] != 3'd0) && hit;
    end else begin : g_no_sb
      assign hazard = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_decode_stage.sv
// Directed bench for pipe_decode_stage; a second instance with HAZ_DEPTH=0 checks the no-stall build.
// Honours ILLEGAL_TRAP_EN when it is defined for the build.
module tb_pipe_decode_stage;
  localparam int unsigned INSTR_W = 12;
  localparam int unsigned SEL_W   = 4;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               flush;
  logic               out_ready;

  logic               in_ready,  in_ready0;
  logic               out_valid, out_valid0;
  logic [INSTR_W-1:0] out_instr, out_instr0;
  logic [SEL_W-1:0]   main_assert, main_assert0;
  logic [SEL_W-1:0]   main_load,   main_load0;
  logic               illegal,     illegal0;

  int n_chk  = 0;
  int n_pass = 0;

  pipe_decode_stage #(.INSTR_W(INSTR_W), .SEL_W(SEL_W), .HAZ_DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .MainAssert(main_assert), .MainLoad(main_load),
    .illegal(illegal)
  );

  pipe_decode_stage #(.INSTR_W(INSTR_W), .SEL_W(SEL_W), .HAZ_DEPTH(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
    .out_instr(out_instr0), .MainAssert(main_assert0), .MainLoad(main_load0),
    .illegal(illegal0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive at the falling edge, then let combinational outputs settle before checking
  task automatic drive(input logic v, input logic [INSTR_W-1:0] ins,
                       input logic fl, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    flush     = fl;
    out_ready = ordy;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [SEL_W-1:0] ld,
                         input logic [SEL_W-1:0] as);
    chk({tag, ".valid"},  32'(out_valid),   32'(v));
    chk({tag, ".load"},   32'(main_load),   32'(ld));
    chk({tag, ".assert"}, 32'(main_assert), 32'(as));
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
    #2 rst_n = 1'b0;

    // Reset held while upstream offers 0x53
    drive(1'b1, 12'h053, 1'b0, 1'b1);
    chk_out("rst", 1'b0, 4'd0, 4'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.illegal",  32'(illegal),  32'd0);
    chk("rst.out_instr", 32'(out_instr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready", 32'(in_ready), 32'd1);

    // Decode sweep at full throughput; upper instruction bits pass through
    drive(1'b1, 12'hA9C, 1'b0, 1'b1);
    chk_out("mov53", 1'b1, 4'd2, 4'd3);
    chk("mov53.instr", 32'(out_instr), 32'h053);
    chk("mov53.in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 12'h00E, 1'b0, 1'b1);
    chk_out("alu9c", 1'b1, 4'd4, 4'd8);
    chk("alu9c.instr", 32'(out_instr), 32'hA9C);
    drive(1'b1, 12'h083, 1'b0, 1'b1);
    chk_out("mvi0e", 1'b1, 4'd6, 4'd5);
    drive(1'b1, 12'h000, 1'b0, 1'b1);
    chk_out("alui83", 1'b1, 4'd4, 4'd8);
    drive(1'b1, 12'h053, 1'b0, 1'b1);
    chk_out("nop", 1'b1, 4'd0, 4'd0);
    chk("nop.illegal", 32'(illegal), 32'd0);

    // Back-pressure: 0x53 held for 3 cycles, next instruction waits
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 12'h00E, 1'b0, 1'b0);
      chk_out("bp", 1'b1, 4'd2, 4'd3);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.instr", 32'(out_instr), 32'h053);
    end
    drive(1'b1, 12'h00E, 1'b0, 1'b1);
    chk("bp.release", 32'(in_ready), 32'd1);

    // Load-use hazard: mvi r6 then mov r1<-r6
    drive(1'b1, 12'h04E, 1'b0, 1'b1);
    chk_out("mvi", 1'b1, 4'd6, 4'd5);
    drive(1'b0, 12'h000, 1'b0, 1'b1);
    chk_out("haz1", 1'b0, 4'd0, 4'd0);
    chk("haz1.in_ready", 32'(in_ready), 32'd0);
    chk("haz1.instr", 32'(out_instr), 32'h04E);
    chk("nohaz.valid",  32'(out_valid0),   32'd1);
    chk("nohaz.load",   32'(main_load0),   32'd1);
    chk("nohaz.assert", 32'(main_assert0), 32'd6);
    drive(1'b0, 12'h000, 1'b0, 1'b1);
    chk_out("haz2", 1'b0, 4'd0, 4'd0);
    drive(1'b0, 12'h000, 1'b0, 1'b1);
    chk_out("hazdone", 1'b1, 4'd1, 4'd6);

    // Flush during a hazard stall, then the same mov presents immediately
    drive(1'b1, 12'h00E, 1'b0, 1'b1);
    drive(1'b1, 12'h04E, 1'b0, 1'b1);
    chk_out("mvi2", 1'b1, 4'd6, 4'd5);
    drive(1'b1, 12'h053, 1'b1, 1'b1);
    chk_out("stall2", 1'b0, 4'd0, 4'd0);
    chk("flush.in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 12'h04E, 1'b0, 1'b1);
    chk("flushed.valid", 32'(out_valid), 32'd0);
    chk("flushed.instr", 32'(out_instr), 32'h04E);
    chk("flushed.in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 12'h000, 1'b0, 1'b1);
    chk_out("postflush", 1'b1, 4'd1, 4'd6);

    // Illegal opcode 0xC0
    drive(1'b1, 12'h0C0, 1'b0, 1'b1);
    chk("pre_ill.illegal", 32'(illegal), 32'd0);
    drive(1'b0, 12'h000, 1'b0, 1'b1);
    chk("ill.illegal", 32'(illegal), 32'd1);
`ifdef ILLEGAL_TRAP_EN
    chk_out("ill", 1'b0, 4'd0, 4'd0);
    chk("ill.in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 12'h053, 1'b0, 1'b1);
    chk("ill.sticky", 32'(illegal), 32'd1);
    chk("ill.sticky_rdy", 32'(in_ready), 32'd0);
    drive(1'b0, 12'h000, 1'b1, 1'b1);
    drive(1'b0, 12'h000, 1'b0, 1'b1);
    chk("ill.cleared", 32'(illegal), 32'd0);
    chk("ill.cleared_rdy", 32'(in_ready), 32'd1);
    chk("ill.cleared_v", 32'(out_valid), 32'd0);
`else
    chk_out("ill", 1'b1, 4'd0, 4'd0);
    drive(1'b0, 12'h000, 1'b0, 1'b1);
    chk("ill.retired", 32'(illegal), 32'd0);
    chk("ill.retired_v", 32'(out_valid), 32'd0);
    chk("ill.in_ready", 32'(in_ready), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
